// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// One bit per cycle (shift-add multiply, restoring divide), sign fix-up in a final cycle.
module mult_div_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 5
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic [2:0]       iOp,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic [WIDTH-1:0] oHI,
   output logic [WIDTH-1:0] oLO,
   output logic             oBusy,
   output logic             oDone,
   output logic             oDivZero
);

   localparam int unsigned PW = 2 * WIDTH;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [PW-1:0]     prod;       // mult: {upper, multiplier}; div: {remainder, quotient}
   logic [WIDTH-1:0]  operand;    // multiplicand or divisor magnitude
   logic              is_div, is_signed, sign_a, sign_b;
   logic [WIDTH-1:0]  hi, lo;
   logic              busy, done, div_zero;

   logic              start_op, start_dz, start_mt;
   logic [WIDTH-1:0]  mag_a, mag_b;
   logic [WIDTH:0]    mul_sum, div_trial;
   logic [PW-1:0]     mul_next, div_next, prod_neg;
   logic [WIDTH-1:0]  fix_hi, fix_lo;

   // Next state and start decode
   always_comb begin
      state_nxt = state;
      start_op  = 1'b0;
      start_dz  = 1'b0;
      start_mt  = 1'b0;
      case (state)
         S_IDLE: begin
            if (iStart) begin
               if (!iOp[2]) begin
                  if (iOp[1] && (iB == '0)) begin
                     start_dz = 1'b1;
                  end else begin
                     start_op  = 1'b1;
                     state_nxt = S_RUN;
                  end
               end else if (!iOp[1]) begin
                  start_mt = 1'b1;
               end
            end
         end
         S_RUN:   if (cnt == LAST_CNT) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // One iteration step of each algorithm, plus the sign-corrected result
   always_comb begin
      mag_a     = (!iOp[0] && iA[WIDTH-1]) ? -iA : iA;
      mag_b     = (!iOp[0] && iB[WIDTH-1]) ? -iB : iB;
      mul_sum   = {1'b0, prod[PW-1:WIDTH]} + (prod[0] ? {1'b0, operand} : '0);
      mul_next  = {mul_sum, prod[WIDTH-1:1]};
      div_trial = {prod[PW-1:WIDTH], prod[WIDTH-1]} - {1'b0, operand};
      div_next  = div_trial[WIDTH] ? {prod[PW-2:0], 1'b0}
                                   : {div_trial[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
      prod_neg  = -prod;
      fix_hi    = prod[PW-1:WIDTH];
      fix_lo    = prod[WIDTH-1:0];
      if (is_signed) begin
         if (!is_div && (sign_a ^ sign_b)) begin
            fix_hi = prod_neg[PW-1:WIDTH];
            fix_lo = prod_neg[WIDTH-1:0];
         end
         if (is_div) begin
            if (sign_a ^ sign_b) fix_lo = -prod[WIDTH-1:0];
            if (sign_a)          fix_hi = -prod[PW-1:WIDTH];
         end
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) state <= S_IDLE;
      else      state <= state_nxt;
   end

   // Datapath and registered outputs
   always_ff @(posedge iCLK) begin
      if (iRST) begin
         hi        <= '0;
         lo        <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         div_zero  <= 1'b0;
         cnt       <= '0;
         prod      <= '0;
         operand   <= '0;
         is_div    <= 1'b0;
         is_signed <= 1'b0;
         sign_a    <= 1'b0;
         sign_b    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_op) begin
                  is_div    <= iOp[1];
                  is_signed <= !iOp[0];
                  sign_a    <= !iOp[0] && iA[WIDTH-1];
                  sign_b    <= !iOp[0] && iB[WIDTH-1];
                  cnt       <= '0;
                  busy      <= 1'b1;
                  div_zero  <= 1'b0;
                  prod      <= {{WIDTH{1'b0}}, iOp[1] ? mag_a : mag_b};
                  operand   <= iOp[1] ? mag_b : mag_a;
               end
               if (start_dz) begin
                  hi       <= iA;
                  lo       <= '1;
                  div_zero <= 1'b1;
                  done     <= 1'b1;
               end
               if (start_mt) begin
                  if (iOp[0]) lo <= iA;
                  else        hi <= iA;
               end
            end
            S_RUN: begin
               cnt  <= cnt + 1'b1;
               prod <= is_div ? div_next : mul_next;
            end
            S_FIX: begin
               hi   <= fix_hi;
               lo   <= fix_lo;
               busy <= 1'b0;
               done <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign oHI      = hi;
   assign oLO      = lo;
   assign oBusy    = busy;
   assign oDone    = done;
   assign oDivZero = div_zero;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases plus random ops
// checked against an arithmetic reference model of HI/LO.
module tb_mult_div_unit;

   logic        iCLK = 1'b0;
   logic        iRST;
   logic        iStart;
   logic [2:0]  iOp;
   logic [31:0] iA, iB;
   logic [31:0] oHI, oLO;
   logic        oBusy, oDone, oDivZero;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;
   logic        m_dz = 1'b0;

   mult_div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
      .oHI(oHI), .oLO(oLO), .oBusy(oBusy), .oDone(oDone), .oDivZero(oDivZero)
   );

   always #5 iCLK = ~iCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference result of a MULT/MULTU/DIV/DIVU as plain arithmetic
   task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] hi, output logic [31:0] lo);
      longint sa, sb, sp;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      hi = '0;
      lo = '0;
      case (op)
         3'd0: begin sp = sa * sb; up = 64'(sp); hi = up[63:32]; lo = up[31:0]; end
         3'd1: begin up = {32'd0, a} * {32'd0, b}; hi = up[63:32]; lo = up[31:0]; end
         3'd2: begin
            if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else begin lo = 32'(sa / sb); hi = 32'(sa % sb); end
         end
         3'd3: begin
            if (b == 0) begin hi = a; lo = 32'hFFFF_FFFF; end
            else begin lo = a / b; hi = a % b; end
         end
         default: ;
      endcase
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, "_hi"}, oHI, m_hi);
      chk({tag, "_lo"}, oLO, m_lo);
      chk({tag, "_dz"}, 32'(oDivZero), 32'(m_dz));
   endtask

   // Issue one op; inject>=0 pulses MTHI 0xAAAA at that cycle of the run
   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inject);
      logic [31:0] r_hi, r_lo;
      int n;
      model(op, a, b, r_hi, r_lo);
      @(negedge iCLK);
      iStart = 1'b1; iOp = op; iA = a; iB = b;
      @(negedge iCLK);
      iStart = 1'b0; iOp = 3'b110;
      if (op == 3'd4 || op == 3'd5) begin
         if (op == 3'd4) m_hi = a; else m_lo = a;
         chk_outs({tag, "_mt"});
         chk({tag, "_mt_busy"}, 32'(oBusy), 32'd0);
         chk({tag, "_mt_done"}, 32'(oDone), 32'd0);
      end else if (op[2]) begin
         chk_outs({tag, "_nop"});
         chk({tag, "_nop_busy"}, 32'(oBusy), 32'd0);
      end else if (op[1] && b == 0) begin
         m_hi = r_hi; m_lo = r_lo; m_dz = 1'b1;
         chk_outs({tag, "_dz"});
         chk({tag, "_dz_done"}, 32'(oDone), 32'd1);
         chk({tag, "_dz_busy"}, 32'(oBusy), 32'd0);
         @(negedge iCLK);
         chk({tag, "_dz_done_end"}, 32'(oDone), 32'd0);
         chk({tag, "_dz_busy_end"}, 32'(oBusy), 32'd0);
      end else begin
         m_dz = 1'b0;
         n = 0;
         while (!oDone && n < 60) begin
            chk({tag, "_run_busy"}, 32'(oBusy), 32'd1);
            chk_outs({tag, "_hold"});
            if (n == inject) begin iStart = 1'b1; iOp = 3'd4; iA = 32'hAAAA; end
            if (n == inject + 1) begin iStart = 1'b0; iOp = 3'b110; end
            @(negedge iCLK);
            n++;
         end
         iStart = 1'b0;
         chk({tag, "_latency"}, 32'(n), 32'd33);
         m_hi = r_hi; m_lo = r_lo;
         chk_outs({tag, "_res"});
         chk({tag, "_busy_end"}, 32'(oBusy), 32'd0);
         @(negedge iCLK);
         chk({tag, "_done_once"}, 32'(oDone), 32'd0);
      end
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      int          r;
      iRST = 1'b1; iStart = 1'b0; iOp = 3'b110; iA = '0; iB = '0;
      repeat (2) @(negedge iCLK);
      iRST = 1'b0;
      chk_outs("reset");
      chk("reset_busy", 32'(oBusy), 32'd0);
      chk("reset_done", 32'(oDone), 32'd0);

      run_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, -1);
      chk("mult_hi_const", oHI, 32'hFFFF_FFFF);
      chk("mult_lo_const", oLO, 32'hFFFF_FFEB);
      run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, -1);
      chk("multu_lo_const", oLO, 32'hFFFF_FFFE);
      run_op("div_neg7", 3'd2, 32'hFFFF_FFF9, 32'd2, -1);
      chk("div_lo_const", oLO, 32'hFFFF_FFFD);
      chk("div_hi_const", oHI, 32'hFFFF_FFFF);
      run_op("divu_100_7", 3'd3, 32'd100, 32'd7, -1);
      run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      chk("div_ovf_lo_const", oLO, 32'h8000_0000);
      run_op("divu_zero", 3'd3, 32'h1234, 32'd0, -1);
      run_op("multu_clr_dz", 3'd1, 32'd5, 32'd6, -1);
      run_op("mult_inject", 3'd0, 32'h1234_5678, 32'hFEDC_BA98, 10);
      run_op("mtlo", 3'd5, 32'h55, 32'd0, -1);
      run_op("nop", 3'd7, 32'hDEAD, 32'd0, -1);

      // Reset in the middle of a DIVU
      @(negedge iCLK);
      iStart = 1'b1; iOp = 3'd3; iA = 32'd1000; iB = 32'd3;
      @(negedge iCLK);
      iStart = 1'b0; iOp = 3'b110;
      repeat (14) @(negedge iCLK);
      iRST = 1'b1;
      @(negedge iCLK);
      iRST = 1'b0;
      m_hi = '0; m_lo = '0; m_dz = 1'b0;
      chk_outs("midreset");
      chk("midreset_busy", 32'(oBusy), 32'd0);
      chk("midreset_done", 32'(oDone), 32'd0);
      run_op("multu_3x4", 3'd1, 32'd3, 32'd4, -1);
      chk("multu_3x4_lo_const", oLO, 32'd12);

      for (int i = 0; i < 30; i++) begin
         r = $urandom_range(0, 11);
         a = $urandom;
         b = $urandom;
         if (r < 8) op = 3'(r % 4);
         else if (r < 10) op = 3'(4 + (r % 2));
         else op = 3'(6 + (r % 2));
         if ($urandom_range(0, 5) == 0) b = 32'(0);
         else if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 20)) * (($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'd1);
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         run_op("rand", op, a, b, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
